// File: rtl/dec_conv_scheduler_if.sv
// ---------------------------------------------------------------------------
// dec_conv_scheduler_if
// Bundles the requester side (req/value/ack/err/digits/ch) and the shared
// binary-to-BCD converter side (start/value/done/bcd) of dec_conv_scheduler.
//
//   master : the scheduler's view (drives ack_o, err_o, digits_o, ch_o,
//            conv_start_o, conv_value_o; reads req_i, value_i, conv_done_i,
//            conv_bcd_i)
//   slave  : the environment's view (requesters plus converter)
//
// Parameters: N_CH channels, WIDTH bits per channel value.
// ---------------------------------------------------------------------------
interface dec_conv_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 12
);
    logic [N_CH-1:0]       req_i;
    logic [N_CH*WIDTH-1:0] value_i;
    logic [N_CH-1:0]       ack_o;
    logic                  err_o;
    logic [31:0]           digits_o;
    logic [2:0]            ch_o;
    logic                  conv_start_o;
    logic [WIDTH-1:0]      conv_value_o;
    logic                  conv_done_i;
    logic [15:0]           conv_bcd_i;

    modport master (
        input  req_i, value_i, conv_done_i, conv_bcd_i,
        output ack_o, err_o, digits_o, ch_o, conv_start_o, conv_value_o
    );

    modport slave (
        output req_i, value_i, conv_done_i, conv_bcd_i,
        input  ack_o, err_o, digits_o, ch_o, conv_start_o, conv_value_o
    );
endinterface

// File: rtl/dec_conv_scheduler.sv
// ---------------------------------------------------------------------------
// dec_conv_scheduler
// Round-robin scheduler sharing one binary-to-BCD converter between N_CH
// requesting channels. The granted channel's value is snapshotted, a start
// pulse is sent to the converter, the scheduler waits for done (abandoning
// the conversion after TIMEOUT cycles) and publishes the result as ASCII.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : dec_conv_scheduler_if.master
//            req_i/value_i  per-channel level requests and packed values
//            ack_o/err_o    one-cycle retire pulse (err_o on timeout)
//            digits_o/ch_o  ASCII {thousands,hundreds,tens,units} + channel
//            conv_*         converter start/value/done/bcd
//
// Parameters: N_CH (2..8), WIDTH, TIMEOUT (>=2).
// Optional feature: define DEC_SCHED_BLANK_EN for leading-zero blanking of
// the thousands/hundreds/tens characters (units always shown).
// ---------------------------------------------------------------------------
module dec_conv_scheduler #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_i,
    dec_conv_scheduler_if.master  bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t           state;
    logic [2:0]       last_q;
    logic [2:0]       grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      bcd_q;

    logic [N_CH-1:0]   ack_q;
    logic              err_q;
    logic              start_q;
    logic [WIDTH-1:0]  conv_value_q;
    logic [31:0]       digits_q;
    logic [2:0]        ch_q;

    // BCD nibbles to ASCII; nibbles above 9 show as '?'.
    function automatic logic [31:0] render(input logic [15:0] bcd);
        logic [31:0] s;
        logic [3:0]  nib;
`ifdef DEC_SCHED_BLANK_EN
        logic        lead;
        lead = 1'b1;
`endif
        s = '0;
        for (int d = 3; d >= 0; d--) begin
            nib = bcd[d*4 +: 4];
            if (nib > 4'd9)
                s[d*8 +: 8] = 8'h3F;
            else
                s[d*8 +: 8] = 8'h30 + {4'h0, nib};
`ifdef DEC_SCHED_BLANK_EN
            // Blank zeros until the first non-zero digit; units never blank.
            if (d != 0 && lead && nib == 4'd0)
                s[d*8 +: 8] = 8'h20;
            else
                lead = 1'b0;
`endif
        end
        return s;
    endfunction

    // Round-robin search: rotate the request vector so that position 0 is
    // last+1, take the lowest set bit, then map the offset back to a channel.
    logic [2*N_CH-1:0] req2;
    logic [N_CH-1:0]   req_rot;
    logic [3:0]        base;
    logic [3:0]        sum;
    logic [2:0]        off;
    logic [2:0]        pick;
    logic              found;
    logic [WIDTH-1:0]  pick_val;

    always_comb begin
        req2    = {bus.req_i, bus.req_i};
        base    = {1'b0, last_q} + 4'd1;
        req_rot = N_CH'(req2 >> base);
        found   = |req_rot;
        off     = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (req_rot[j]) off = 3'(j);
        end
        sum = base + {1'b0, off};
        if (sum >= 4'(N_CH)) sum = sum - 4'(N_CH);
        pick = sum[2:0];

        pick_val = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (pick == 3'(k)) pick_val = bus.value_i[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            last_q       <= 3'(N_CH - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            bcd_q        <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            conv_value_q <= '0;
            digits_q     <= 32'h3030_3030;
            ch_q         <= '0;
        end else begin
            ack_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_q      <= pick;
                        last_q       <= pick;
                        conv_value_q <= pick_val;
                        start_q      <= 1'b1;  // high for the LAUNCH cycle only
                        state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt_q <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done has priority over the timeout on the final cycle.
                    if (bus.conv_done_i) begin
                        bcd_q <= bus.conv_bcd_i;
                        ack_q <= N_CH'(1) << grant_q;  // visible during CAPTURE
                        state <= S_CAPTURE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                        // Incrementing would reach TIMEOUT-1: abandon.
                        ack_q <= N_CH'(1) << grant_q;
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    digits_q <= render(bcd_q);
                    ch_q     <= grant_q;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack_o        = ack_q;
    assign bus.err_o        = err_q;
    assign bus.conv_start_o = start_q;
    assign bus.conv_value_o = conv_value_q;
    assign bus.digits_o     = digits_q;
    assign bus.ch_o         = ch_q;

endmodule

// File: tb/tb_dec_conv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dec_conv_scheduler
// Scoreboard bench: each phase predicts the grant order from the set of held
// requests, pushes expected starts/acks, and a monitor checks the DUT as it
// presents conv_start_o and ack_o. A behavioural converter answers starts
// after a per-conversion delay (or never, to force a timeout).
// ---------------------------------------------------------------------------
module tb_dec_conv_scheduler;
    localparam int N_CH    = 4;
    localparam int WIDTH   = 12;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    dec_conv_scheduler_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    dec_conv_scheduler #(.N_CH(N_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct { int ch; logic [WIDTH-1:0] value; } start_t;
    typedef struct { int ch; bit err; logic [31:0] digits; int ch_after; } ack_t;
    typedef struct { int delay; bit ovr; logic [15:0] bcd; } conv_t;  // delay 0: never

    start_t start_q[$];
    ack_t   ack_q[$];
    conv_t  conv_q[$];
    int     cyc_q[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit spur_en = 1'b0;

    int          model_last;
    logic [31:0] model_digits;
    int          model_ch;

    logic [WIDTH-1:0] ph_val[N_CH];
    conv_t            ph_cv[N_CH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Text expected on the display for a BCD word.
    function automatic logic [31:0] ascii(input logic [15:0] b);
        logic [31:0] s;
        logic [3:0]  n;
`ifdef DEC_SCHED_BLANK_EN
        int msd;
        msd = 0;
        for (int d = 0; d < 4; d++) if (b[d*4 +: 4] != 4'd0) msd = d;
`endif
        s = '0;
        for (int d = 0; d < 4; d++) begin
            n = b[d*4 +: 4];
            s[d*8 +: 8] = (n > 4'd9) ? 8'h3F : 8'h30 + 8'(n);
`ifdef DEC_SCHED_BLANK_EN
            if (d > msd) s[d*8 +: 8] = 8'h20;
`endif
        end
        return s;
    endfunction

    // Behavioural converter.
    initial begin : converter
        conv_t       c;
        logic [15:0] r;
        logic [WIDTH-1:0] snap;
        int          s_cyc;
        bus.conv_done_i = 1'b0;
        bus.conv_bcd_i  = '0;
        forever begin
            @(negedge clk);
            bus.conv_done_i = 1'b0;
            if (bus.conv_start_o && !rst_i) begin
                s_cyc = cyc;
                snap  = bus.conv_value_o;
                if (conv_q.size() > 0) c = conv_q.pop_front();
                else c = '{0, 1'b0, 16'h0};
                r = c.ovr ? c.bcd : to_bcd(int'(snap));
                if (c.delay == 0) begin
                    cyc_q.push_back(s_cyc + TIMEOUT);
                    repeat (TIMEOUT) @(negedge clk);
                end else begin
                    cyc_q.push_back(s_cyc + c.delay + 1);
                    repeat (c.delay) @(negedge clk);
                    if (!rst_i) chk("conv_value_stable", bus.conv_value_o, snap);
                    bus.conv_done_i = 1'b1;
                    bus.conv_bcd_i  = r;
                end
            end else if (spur_en && $urandom_range(7, 0) == 0) begin
                // Stray done while no conversion is outstanding.
                bus.conv_done_i = 1'b1;
                bus.conv_bcd_i  = 16'h9999;
            end
        end
    end

    // Monitor / scoreboard.
    bit          dig_pend = 1'b0;
    logic [31:0] dig_exp;
    int          ch_exp;
    start_t      mon_s;
    ack_t        mon_a;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dig_pend) begin
                chk("digits_o", bus.digits_o, dig_exp);
                chk("ch_o", 64'(bus.ch_o), 64'(ch_exp));
                dig_pend = 1'b0;
            end
            if (bus.conv_start_o) begin
                if (start_q.size() == 0) fail_now("conv_start_o", "unexpected start pulse");
                else begin
                    mon_s = start_q.pop_front();
                    chk("conv_value_o", bus.conv_value_o, mon_s.value);
                end
            end
            if (bus.ack_o != '0) begin
                if (ack_q.size() == 0) fail_now("ack_o", "unexpected ack pulse");
                else begin
                    mon_a = ack_q.pop_front();
                    chk("ack_o", bus.ack_o, N_CH'(1) << mon_a.ch);
                    chk("err_o", bus.err_o, mon_a.err);
                    if (cyc_q.size() == 0) fail_now("ack_cycle", "ack with no recorded start");
                    else chk("ack_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
                    dig_pend = 1'b1;
                    dig_exp  = mon_a.digits;
                    ch_exp   = mon_a.ch_after;
                end
            end else if (bus.err_o) begin
                fail_now("err_o", "err pulse without ack");
            end
        end
    end

    // Hold the requests in mask, predict the round-robin order and the
    // per-conversion results, then run until every request is retired.
    task automatic run_phase(input logic [N_CH-1:0] mask);
        bit   pend[N_CH];
        int   order[$];
        int   k, nstart, nack, g;
        bit   hit;
        ack_t a;
        logic [15:0] b;
        for (int i = 0; i < N_CH; i++) pend[i] = mask[i];
        while (order.size() < $countones(mask)) begin
            hit = 1'b0;
            k   = 0;
            for (int step = 1; step <= N_CH; step++) begin
                if (!hit && pend[(model_last + step) % N_CH]) begin
                    k   = (model_last + step) % N_CH;
                    hit = 1'b1;
                end
            end
            pend[k] = 1'b0;
            order.push_back(k);
            model_last = k;
        end
        foreach (order[j]) begin
            g = order[j];
            start_q.push_back('{g, ph_val[g]});
            conv_q.push_back(ph_cv[g]);
            a.ch  = g;
            a.err = (ph_cv[g].delay == 0);
            if (!a.err) begin
                b = ph_cv[g].ovr ? ph_cv[g].bcd : to_bcd(int'(ph_val[g]));
                model_digits = ascii(b);
                model_ch     = g;
            end
            a.digits   = model_digits;
            a.ch_after = model_ch;
            ack_q.push_back(a);
        end
        for (int i = 0; i < N_CH; i++) bus.value_i[i*WIDTH +: WIDTH] = ph_val[i];
        bus.req_i = mask;
        nstart = 0;
        nack   = 0;
        for (int c = 0; c < 70 * N_CH + 20 && nack < order.size(); c++) begin
            @(negedge clk);
            if (bus.conv_start_o && nstart < order.size()) begin
                g = order[nstart];
                nstart++;
                // Snapshot must already be taken: disturb the live value,
                // and sometimes withdraw the request.
                bus.value_i[g*WIDTH +: WIDTH] = WIDTH'($urandom);
                if ($urandom_range(1, 0) == 1) bus.req_i[g] = 1'b0;
            end
            if (bus.ack_o != '0) begin
                bus.req_i = bus.req_i & ~bus.ack_o;
                nack++;
            end
        end
        chk("phase_ack_count", 64'(nack), 64'(order.size()));
        bus.req_i = '0;
        repeat (3) @(negedge clk);
    endtask

    function automatic conv_t rand_cv();
        conv_t c;
        c.ovr = 1'b0;
        c.bcd = '0;
        case ($urandom_range(7, 0))
            0:       c.delay = 0;
            1:       c.delay = 63;
            default: c.delay = $urandom_range(20, 1);
        endcase
        return c;
    endfunction

    initial begin : watchdog
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish within budget");
        $fatal(1);
    end

    initial begin : main
        logic [N_CH-1:0] m;
        rst_i        = 1'b1;
        bus.req_i    = '0;
        bus.value_i  = '0;
        model_last   = N_CH - 1;
        model_digits = 32'h3030_3030;
        model_ch     = 0;
        repeat (3) @(negedge clk);
        chk("reset_digits", bus.digits_o, 32'h3030_3030);
        chk("reset_ch", 64'(bus.ch_o), 64'd0);
        chk("reset_ack", 64'(bus.ack_o), 64'd0);
        chk("reset_start", 64'(bus.conv_start_o), 64'd0);
        chk("reset_err", 64'(bus.err_o), 64'd0);
        rst_i   = 1'b0;
        mon_en  = 1'b1;
        spur_en = 1'b1;
        repeat (4) @(negedge clk);

        // All four held: fairness from reset, order 0,1,2,3.
        for (int i = 0; i < N_CH; i++) begin
            ph_val[i] = WIDTH'($urandom_range(4095, 0));
            ph_cv[i]  = '{$urandom_range(30, 1), 1'b0, 16'h0};
        end
        run_phase(4'b1111);

        // Single request, ch2 = 1234, done 26 cycles after start.
        ph_val[2] = 12'd1234;
        ph_cv[2]  = '{26, 1'b0, 16'h0};
        run_phase(4'b0100);

        // ch0 next in rotation after the previous grant.
        ph_val[0] = 12'd555;
        ph_cv[0]  = '{3, 1'b0, 16'h0};
        run_phase(4'b0001);

        // Converter never answers: timeout, digits kept.
        ph_val[1] = 12'd999;
        ph_cv[1]  = '{0, 1'b0, 16'h0};
        run_phase(4'b0010);

        // Done on the very last wait cycle wins; shortest delay too.
        ph_val[0] = 12'd42;
        ph_cv[0]  = '{63, 1'b0, 16'h0};
        ph_val[3] = 12'd3001;
        ph_cv[3]  = '{1, 1'b0, 16'h0};
        run_phase(4'b1001);

        // Non-decimal nibble rendered as '?'.
        ph_val[0] = 12'd1;
        ph_cv[0]  = '{5, 1'b1, 16'h12A4};
        run_phase(4'b0001);

        // Leading zeros, full scale and zero.
        ph_val[0] = 12'd7;
        ph_val[1] = 12'd4095;
        ph_val[2] = 12'd0;
        for (int i = 0; i < 3; i++) ph_cv[i] = '{$urandom_range(10, 1), 1'b0, 16'h0};
        run_phase(4'b0111);

        // Randomized phases.
        for (int p = 0; p < 15; p++) begin
            m = N_CH'($urandom_range(15, 1));
            for (int i = 0; i < N_CH; i++) begin
                ph_val[i] = WIDTH'($urandom_range(4095, 0));
                ph_cv[i]  = rand_cv();
            end
            run_phase(m);
        end
        chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        chk("start_queue_drained", 64'(start_q.size()), 64'd0);

        // Reset in the middle of a wait on ch1.
        start_q.push_back('{1, 12'd2222});
        conv_q.push_back('{0, 1'b0, 16'h0});
        bus.value_i[1*WIDTH +: WIDTH] = 12'd2222;
        bus.req_i = 4'b0010;
        for (int c = 0; c < 20 && !bus.conv_start_o; c++) @(negedge clk);
        chk("reset_test_started", 64'(bus.conv_start_o), 64'd1);
        bus.req_i = '0;
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("midrun_reset_digits", bus.digits_o, 32'h3030_3030);
        chk("midrun_reset_ch", 64'(bus.ch_o), 64'd0);
        chk("midrun_reset_ack", 64'(bus.ack_o), 64'd0);
        chk("midrun_reset_start", 64'(bus.conv_start_o), 64'd0);
        chk("midrun_reset_value", 64'(bus.conv_value_o), 64'd0);
        repeat (2) @(negedge clk);
        ack_q.delete();
        start_q.delete();
        cyc_q.delete();
        model_last   = N_CH - 1;
        model_digits = 32'h3030_3030;
        model_ch     = 0;
        rst_i = 1'b0;
        // Let the abandoned conversion drain from the converter model; no
        // ack or err may appear meanwhile.
        repeat (TIMEOUT + 5) @(negedge clk);

        // Pointer restarted: ch0 wins first again.
        for (int i = 0; i < N_CH; i++) begin
            ph_val[i] = WIDTH'($urandom_range(4095, 0));
            ph_cv[i]  = '{$urandom_range(8, 1), 1'b0, 16'h0};
        end
        run_phase(4'b1111);
        chk("final_ack_queue_drained", 64'(ack_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
